// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg -- shared definitions for the SPI slave front end.
//   SPI_BYTE_W      : width of one SPI transfer unit (8)
//   SPI_BIT_CNT_W   : width of the in-byte bit counter (3)
//   SPI_CPOL/CPHA   : mode-0 definition (idle-low clock, sample on leading edge)
//   SPI_SCK_IDLE    : synchronizer reset value for sck (idle level)
//   SPI_CS_IDLE     : synchronizer reset value for cs_n (deselected)
//   spi_shift_in()  : MSB-first shift of one received bit into a byte
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package spi_pkg;

   localparam int SPI_BYTE_W    = 8;
   localparam int SPI_BIT_CNT_W = 3;

   typedef logic [SPI_BYTE_W-1:0]    spi_byte_t;
   typedef logic [SPI_BIT_CNT_W-1:0] spi_bit_cnt_t;

   // Supported SPI modes; only mode 0 is implemented by this block.
   typedef enum logic [1:0] {
      SPI_MODE0 = 2'd0,
      SPI_MODE1 = 2'd1,
      SPI_MODE2 = 2'd2,
      SPI_MODE3 = 2'd3
   } spi_mode_e;

   localparam spi_mode_e SPI_MODE     = SPI_MODE0;
   localparam logic      SPI_CPOL     = 1'b0;
   localparam logic      SPI_CPHA     = 1'b0;
   localparam logic      SPI_SCK_IDLE = SPI_CPOL;
   localparam logic      SPI_CS_IDLE  = 1'b1;

   // Counter value of the last bit of a byte; the edge sampling it wraps to 0.
   localparam spi_bit_cnt_t SPI_LAST_BIT = 3'd7;

   // Shift one serial bit into the LSB, older bits move towards the MSB.
   function automatic spi_byte_t spi_shift_in(input spi_byte_t cur, input logic din);
      return {cur[SPI_BYTE_W-2:0], din};
   endfunction

endpackage : spi_pkg

// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if -- SPI pins plus the controller-side byte handshake.
//   spi_sck, spi_cs_n, spi_mosi : host -> device serial pins (asynchronous)
//   spi_miso                    : device -> host serial data
//   spi_tsx_start               : one-clk pulse per transaction start
//   spi_c_data_in/_stb          : received byte and its one-clk valid strobe
//   spi_c_data_out              : reply byte supplied by the controller
//   spi_miso_oe                 : miso output enable, only with
//                                 SPI_SLAVE_MISO_OE_EN defined
// Modports: slave (the spi_slave block), master (host + controller side).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface spi_slave_if;
   import spi_pkg::*;

   logic      spi_sck;
   logic      spi_cs_n;
   logic      spi_mosi;
   logic      spi_miso;
   logic      spi_tsx_start;
   spi_byte_t spi_c_data_in;
   logic      spi_c_data_stb;
   spi_byte_t spi_c_data_out;
`ifdef SPI_SLAVE_MISO_OE_EN
   logic      spi_miso_oe;
`endif

`ifdef SPI_SLAVE_MISO_OE_EN
   modport slave (
      input  spi_sck, spi_cs_n, spi_mosi, spi_c_data_out,
      output spi_miso, spi_tsx_start, spi_c_data_in, spi_c_data_stb, spi_miso_oe
   );
   modport master (
      output spi_sck, spi_cs_n, spi_mosi, spi_c_data_out,
      input  spi_miso, spi_tsx_start, spi_c_data_in, spi_c_data_stb, spi_miso_oe
   );
`else
   modport slave (
      input  spi_sck, spi_cs_n, spi_mosi, spi_c_data_out,
      output spi_miso, spi_tsx_start, spi_c_data_in, spi_c_data_stb
   );
   modport master (
      output spi_sck, spi_cs_n, spi_mosi, spi_c_data_out,
      input  spi_miso, spi_tsx_start, spi_c_data_in, spi_c_data_stb
   );
`endif

endinterface : spi_slave_if

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync -- single-bit multi-flop synchronizer with edge pulses.
//   clk, rst : system clock, asynchronous active-low reset
//   d        : asynchronous input
//   q        : synchronized level (last synchronizer stage)
//   rise     : one-clk pulse when q goes 0 -> 1
//   fall     : one-clk pulse when q goes 1 -> 0
// STAGES (2..3) sets the synchronizer depth; RST_VAL is the level the chain
// and the edge detector reset to, so releasing reset never shows an edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain_r;
   logic              prev_r;

   // Synchronizer chain plus a one-clk delayed copy of its output for edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chain_r <= {STAGES{RST_VAL}};
         prev_r  <= RST_VAL;
      end else begin
         chain_r <= {chain_r[STAGES-2:0], d};
         prev_r  <= chain_r[STAGES-1];
      end
   end

   assign q    = chain_r[STAGES-1];
   assign rise = chain_r[STAGES-1] & ~prev_r;
   assign fall = ~chain_r[STAGES-1] & prev_r;

endmodule : spi_sync

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave -- mode-0 SPI slave byte engine.
//   clk   : system clock (sck must be at most clk/8)
//   rst   : asynchronous active-low reset
//   bus   : spi_slave_if.slave -- SPI pins and controller byte handshake
// Receives MSB-first bytes on mosi, presents each completed byte with a
// one-clk strobe, and shifts the controller's reply byte out on miso.
// Optional build macro SPI_SLAVE_MISO_OE_EN adds bus.spi_miso_oe, high while
// the synchronized chip select is active.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_slave
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   spi_slave_if.slave  bus
);

   logic sck_q_unused_s;
   logic sck_rise_s;
   logic sck_fall_s;
   logic cs_n_q_s;
   logic cs_rise_unused_s;
   logic cs_fall_s;
   logic mosi_q_s;
   logic mosi_rise_unused_s;
   logic mosi_fall_unused_s;
   logic sample_edge_s;
   logic change_edge_s;

   spi_bit_cnt_t bit_cnt_r;
   spi_byte_t    rx_sr_r;
   spi_byte_t    tx_sr_r;
   spi_byte_t    data_in_r;
   logic         data_stb_r;
   logic         tsx_start_r;
   logic         tx_load_r;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_SCK_IDLE)) u_sync_sck (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.spi_sck),
      .q    (sck_q_unused_s),
      .rise (sck_rise_s),
      .fall (sck_fall_s)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CS_IDLE)) u_sync_cs_n (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.spi_cs_n),
      .q    (cs_n_q_s),
      .rise (cs_rise_unused_s),
      .fall (cs_fall_s)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.spi_mosi),
      .q    (mosi_q_s),
      .rise (mosi_rise_unused_s),
      .fall (mosi_fall_unused_s)
   );

   // mosi and sck share the synchronizer depth, so mosi_q_s is aligned with
   // the sampled sck edge. Mode 0 samples on the rising (leading) edge and
   // moves miso on the falling (trailing) edge.
   assign sample_edge_s = (SPI_CPOL ^ SPI_CPHA) ? sck_fall_s : sck_rise_s;
   assign change_edge_s = (SPI_CPOL ^ SPI_CPHA) ? sck_rise_s : sck_fall_s;

   // Receive path, transaction framing and the reply shift register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt_r   <= 3'd0;
         rx_sr_r     <= 8'h00;
         tx_sr_r     <= 8'h00;
         data_in_r   <= 8'h00;
         data_stb_r  <= 1'b0;
         tsx_start_r <= 1'b0;
         tx_load_r   <= 1'b0;
      end else begin
         tsx_start_r <= cs_fall_s;
         data_stb_r  <= 1'b0;
         // Reply is captured one clk after each start/strobe pulse, giving the
         // controller a full registered cycle to present the next byte.
         tx_load_r   <= tsx_start_r | data_stb_r;

         if (cs_fall_s) begin
            bit_cnt_r <= 3'd0;
            rx_sr_r   <= 8'h00;
         end else if (cs_n_q_s) begin
            // Deselected: any partial byte is abandoned and edges are ignored,
            // including a final edge seen in the same clk as deselect.
            bit_cnt_r <= 3'd0;
         end else if (sample_edge_s) begin
            rx_sr_r   <= spi_shift_in(rx_sr_r, mosi_q_s);
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == SPI_LAST_BIT) begin
               data_in_r  <= spi_shift_in(rx_sr_r, mosi_q_s);
               data_stb_r <= 1'b1;
            end
         end

         // The trailing edge after a completed byte (counter 0) must not shift:
         // the freshly loaded reply's MSB has to be on miso for the next bit.
         if (tx_load_r) begin
            tx_sr_r <= bus.spi_c_data_out;
         end else if (!cs_n_q_s && change_edge_s && (bit_cnt_r != 3'd0)) begin
            tx_sr_r <= {tx_sr_r[SPI_BYTE_W-2:0], 1'b0};
         end
      end
   end

   assign bus.spi_miso       = tx_sr_r[SPI_BYTE_W-1];
   assign bus.spi_tsx_start  = tsx_start_r;
   assign bus.spi_c_data_in  = data_in_r;
   assign bus.spi_c_data_stb = data_stb_r;

`ifdef SPI_SLAVE_MISO_OE_EN
   // Direct copy of the synchronized select flop (reset value deselected).
   assign bus.spi_miso_oe = ~cs_n_q_s;
`endif

endmodule : spi_slave

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave -- self-checking bench for spi_slave.
// A host model bit-bangs mode-0 frames at clk/10, a controller model answers
// each strobe with the next queued reply, and a reference model derives the
// expected received bytes, strobe/start counts and miso bytes from the frames.
// Honors SPI_SLAVE_MISO_OE_EN for the optional output-enable checks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_slave;
   import spi_pkg::*;

   localparam time CLK_HALF = 5;
   localparam time SCK_HALF = 50;

   logic clk = 1'b0;
   logic rst;

   spi_slave_if bus ();

   spi_slave #(.SYNC_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #CLK_HALF clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   int tsx_cnt = 0;
   int stb_cnt = 0;
   int tsx_run = 0;
   int stb_run = 0;
   int tsx_max_run = 0;
   int stb_max_run = 0;

   logic [7:0] rx_q[$];
   logic [7:0] reply_q[$];
   logic [7:0] preset_q[$];
   logic [7:0] host_tx_q[$];
   logic [7:0] host_miso_q[$];
   logic [7:0] exp_rep_q[$];
   logic [7:0] exp_dout0;
   logic [7:0] model_last_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Observer and controller model: counts pulses, captures strobed bytes and
   // answers each strobe with the next reply within the same clk.
   always @(negedge clk) begin
      if (bus.spi_tsx_start === 1'b1) begin
         tsx_cnt++;
         tsx_run++;
         if (tsx_run > tsx_max_run) tsx_max_run = tsx_run;
      end else begin
         tsx_run = 0;
      end
      if (bus.spi_c_data_stb === 1'b1) begin
         stb_cnt++;
         stb_run++;
         if (stb_run > stb_max_run) stb_max_run = stb_run;
         rx_q.push_back(bus.spi_c_data_in);
      end else begin
         stb_run = 0;
      end
      if (bus.spi_c_data_stb === 1'b1 && reply_q.size() > 0) begin
         bus.spi_c_data_out = reply_q.pop_front();
      end else if (preset_q.size() > 0) begin
         bus.spi_c_data_out = preset_q.pop_front();
      end
   end

   task automatic set_dout(input logic [7:0] v);
      preset_q.push_back(v);
      @(negedge clk);
      @(negedge clk);
   endtask

   // One chip-select frame: all bytes of host_tx_q, then 'tail' stray bits;
   // 'cut' raises cs_n together with the final rising sck edge.
   task automatic xfer(input int tail, input bit cut);
      logic [7:0] b;
      logic [7:0] m;
      int n;
      n = host_tx_q.size();
      bus.spi_cs_n = 1'b0;
      #(SCK_HALF);
`ifdef SPI_SLAVE_MISO_OE_EN
      chk("miso_oe active", {31'd0, bus.spi_miso_oe}, 32'd1);
`endif
      for (int i = 0; i < n; i++) begin
         b = host_tx_q[i];
         m = 8'h00;
         for (int j = 7; j >= 0; j--) begin
            bus.spi_mosi = b[j];
            #(SCK_HALF);
            m[j] = bus.spi_miso;
            bus.spi_sck = 1'b1;
            if (cut && (i == n - 1) && (j == 0)) bus.spi_cs_n = 1'b1;
            #(SCK_HALF);
            bus.spi_sck = 1'b0;
         end
         host_miso_q.push_back(m);
      end
      for (int t = 0; t < tail; t++) begin
         bus.spi_mosi = 1'($urandom_range(0, 1));
         #(SCK_HALF);
         bus.spi_sck = 1'b1;
         #(SCK_HALF);
         bus.spi_sck = 1'b0;
      end
      #(SCK_HALF);
      bus.spi_cs_n = 1'b1;
      #(2 * SCK_HALF);
`ifdef SPI_SLAVE_MISO_OE_EN
      chk("miso_oe idle", {31'd0, bus.spi_miso_oe}, 32'd0);
`endif
   endtask

   // Runs one frame and checks it against the reference model.
   task automatic txn(input string tag, input int tail, input bit cut);
      int tsx0;
      int stb0;
      int n;
      int n_full;
      logic [7:0] exp_m;
      tsx0 = tsx_cnt;
      stb0 = stb_cnt;
      rx_q.delete();
      host_miso_q.delete();
      reply_q = exp_rep_q;
      n = host_tx_q.size();
      n_full = cut ? n - 1 : n;
      xfer(tail, cut);
      chk({tag, " tsx_start count"}, tsx_cnt - tsx0, 32'd1);
      chk({tag, " stb count"}, stb_cnt - stb0, n_full);
      chk({tag, " rx byte count"}, rx_q.size(), n_full);
      for (int k = 0; k < n_full && k < rx_q.size(); k++)
         chk({tag, " rx byte"}, {24'd0, rx_q[k]}, {24'd0, host_tx_q[k]});
      if (n_full > 0) model_last_in = host_tx_q[n_full - 1];
      chk({tag, " data_in hold"}, {24'd0, bus.spi_c_data_in}, {24'd0, model_last_in});
      for (int k = 0; k < n && k < host_miso_q.size(); k++) begin
         exp_m = (k == 0) ? exp_dout0 : exp_rep_q[k - 1];
         chk({tag, " miso byte"}, {24'd0, host_miso_q[k]}, {24'd0, exp_m});
      end
   endtask

   task automatic prep(input logic [7:0] dout0, input int nrep);
      exp_dout0 = dout0;
      set_dout(dout0);
      exp_rep_q.delete();
      for (int k = 0; k < nrep; k++) exp_rep_q.push_back(8'($urandom));
   endtask

   initial begin
      int tsx0;
      int stb0;
      int n;
      int tail;
      bit cut;

      rst          = 1'b0;
      bus.spi_cs_n = 1'b1;
      bus.spi_sck  = 1'b0;
      bus.spi_mosi = 1'b0;
      model_last_in = 8'h00;
      preset_q.push_back(8'h00);
      repeat (3) @(negedge clk);

      // Reset values
      chk("reset miso", {31'd0, bus.spi_miso}, 32'd0);
      chk("reset tsx_start", {31'd0, bus.spi_tsx_start}, 32'd0);
      chk("reset stb", {31'd0, bus.spi_c_data_stb}, 32'd0);
      chk("reset data_in", {24'd0, bus.spi_c_data_in}, 32'd0);
`ifdef SPI_SLAVE_MISO_OE_EN
      chk("reset miso_oe", {31'd0, bus.spi_miso_oe}, 32'd0);
`endif
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // A5 received, 3C replied
      host_tx_q = '{8'hA5};
      prep(8'h3C, 1);
      txn("A5/3C", 0, 1'b0);

      // Two bytes in one frame; reply 81 after the first strobe
      host_tx_q = '{8'h01, 8'h02};
      prep(8'h55, 0);
      exp_rep_q = '{8'h81, 8'h00};
      txn("two byte", 0, 1'b0);

      // Partial 5-bit frame is discarded
      host_tx_q.delete();
      prep(8'h00, 0);
      txn("partial5", 5, 1'b0);
      host_tx_q = '{8'hFF};
      prep(8'h96, 1);
      txn("FF after partial", 0, 1'b0);

      // Final rising edge coincident with deselect is ignored
      host_tx_q = '{8'hC3};
      prep(8'h18, 1);
      txn("edge with deselect", 0, 1'b1);

      // sck toggling while deselected produces nothing
      tsx0 = tsx_cnt;
      stb0 = stb_cnt;
      for (int i = 0; i < 8; i++) begin
         bus.spi_mosi = 1'b1;
         #(SCK_HALF);
         bus.spi_sck = 1'b1;
         #(SCK_HALF);
         bus.spi_sck = 1'b0;
      end
      #(2 * SCK_HALF);
      chk("idle sck tsx_start", tsx_cnt - tsx0, 32'd0);
      chk("idle sck stb", stb_cnt - stb0, 32'd0);

      // Reset in the middle of a frame
      set_dout(8'hE7);
      tsx0 = tsx_cnt;
      bus.spi_cs_n = 1'b0;
      #(SCK_HALF);
      for (int i = 0; i < 3; i++) begin
         bus.spi_mosi = 1'b1;
         #(SCK_HALF);
         bus.spi_sck = 1'b1;
         #(SCK_HALF);
         bus.spi_sck = 1'b0;
      end
      chk("pre-reset tsx_start", tsx_cnt - tsx0, 32'd1);
      #(SCK_HALF / 2);
      rst = 1'b0;
      bus.spi_cs_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid reset miso", {31'd0, bus.spi_miso}, 32'd0);
      chk("mid reset tsx_start", {31'd0, bus.spi_tsx_start}, 32'd0);
      chk("mid reset stb", {31'd0, bus.spi_c_data_stb}, 32'd0);
      chk("mid reset data_in", {24'd0, bus.spi_c_data_in}, 32'd0);
`ifdef SPI_SLAVE_MISO_OE_EN
      chk("mid reset miso_oe", {31'd0, bus.spi_miso_oe}, 32'd0);
`endif
      model_last_in = 8'h00;
      tsx0 = tsx_cnt;
      stb0 = stb_cnt;
      rst = 1'b1;
      repeat (10) @(negedge clk);
      chk("post reset tsx_start", tsx_cnt - tsx0, 32'd0);
      chk("post reset stb", stb_cnt - stb0, 32'd0);
      host_tx_q = '{8'h5A};
      prep(8'hA3, 1);
      txn("5A after reset", 0, 1'b0);

      // Randomized frames
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(1, 3);
         tail = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
         cut = (tail == 0) && ($urandom_range(0, 3) == 0);
         host_tx_q.delete();
         for (int k = 0; k < n; k++) host_tx_q.push_back(8'($urandom));
         prep(8'($urandom), n);
         txn("random", tail, cut);
      end

      chk("stb single pulse", stb_max_run, 32'd1);
      chk("tsx_start single pulse", tsx_max_run, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_spi_slave
